// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding fetch at a time and
// buffers the returned word for IF/ID, squashing in-flight fetches on redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        pcsrc,
  input  logic [31:0] pcbranch,
  input  logic        jump,
  input  logic [31:0] pcjump,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pcplus4_IF,
  output logic [31:0] instr_IF,
  output logic        fetch_stall,
  output logic        flush_ID
);

  typedef enum logic [1:0] {StFetch, StWait, StReady, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign valid    = (state_q == StReady);
  assign redirect = jump | pcsrc;
  // Jump wins if both are asserted.
  assign target   = jump ? pcjump : pcbranch;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (redirect) pc_d = target;
    unique case (state_q)
      StFetch: begin
        // An accepted request must still be drained if we redirect on the same edge.
        if (imem_req_ready) state_d = redirect ? StDrain : StWait;
      end
      StWait: begin
        if (redirect) begin
          state_d = imem_rsp_valid ? StFetch : StDrain;
        end else if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = StReady;
        end
      end
      StReady: begin
        if (redirect) begin
          state_d = StFetch;
        end else if (!stall_i) begin
          pc_d    = pc_plus4;
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (imem_rsp_valid) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // State resets to FETCH, so the request must be masked while reset is held.
  assign imem_req_valid = (state_q == StFetch) && reset_n;
  assign imem_addr      = pc_q;
  assign pcplus4_IF     = pc_plus4;
  assign instr_IF       = valid ? instr_q : NOP_INSTR;
  assign fetch_stall    = !valid;
  assign flush_ID       = redirect;

endmodule
